// File: rtl/k2_ctrl_pkg.sv
// Shared types and default widths for the K2 run controller.
// The state encoding is visible on state_o, so its order is fixed here.
package k2_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int INST_W_DEF = 8;
  localparam int CYC_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } state_t;

endpackage

// File: rtl/k2_prog_ram.sv
// K2 program store: synchronous write, asynchronous read, contents never reset.
// A read of the address being written returns the old word until the edge.
module k2_prog_ram #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_run_controller.sv
// K2 sequencer: owns the program RAM, byte-stream loader and core reset/enable.
// Define K2_BREAKPOINT_EN to add the single address breakpoint (bp_en/bp_addr/bp_hit).
module k2_run_controller
  import k2_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [INST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              run_start,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [ADDR_W-1:0] ProgramAddress,
  output logic [INST_W-1:0] instruction_data,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [2:0]        state_o,
`ifdef K2_BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [CYC_W-1:0]  cycle_count
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [CYC_W-1:0]  CNT_MAX  = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ram_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef K2_BREAKPOINT_EN
  logic resume_mask;
  logic bp_trap;
`endif

  // Next state; a full 2^ADDR_W byte load ends the LOAD phase on its own.
  always_comb begin
    state_next = state;
`ifdef K2_BREAKPOINT_EN
    bp_trap = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (load_start)     state_next = LOAD;
        else if (run_start) state_next = RUN;
      end
      LOAD: begin
        if (ld_valid && (wr_ptr == PTR_LAST)) state_next = IDLE;
      end
      RUN: begin
        if (load_start)    state_next = LOAD;
        else if (halt_req) state_next = HALT;
`ifdef K2_BREAKPOINT_EN
        else if (bp_en && (ProgramAddress == bp_addr) && !resume_mask) begin
          state_next = HALT;
          bp_trap    = 1'b1;
        end
`endif
      end
      STEP: state_next = HALT;
      HALT: begin
        if (load_start)     state_next = LOAD;
        else if (run_start) state_next = RUN;
        else if (step_req)  state_next = STEP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_rst  = (state == IDLE) || (state == LOAD);
  assign cpu_en   = (state == RUN) || (state == STEP);
  assign ld_ready = (state == LOAD);
  assign state_o  = state;
  assign ram_we   = ld_ready && ld_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if ((state != LOAD) && (state_next == LOAD)) begin
      wr_ptr <= '0;
    end else if (ram_we) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Counts enabled core cycles; only a fresh run from IDLE clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if ((state == IDLE) && (state_next == RUN)) begin
      cycle_count <= '0;
    end else if (cpu_en && (cycle_count != CNT_MAX)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

`ifdef K2_BREAKPOINT_EN
  // The first RUN cycle after HALT skips the compare so a resume is not re-trapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resume_mask <= 1'b0;
      bp_hit      <= 1'b0;
    end else begin
      resume_mask <= (state == HALT) && (state_next == RUN);
      if (bp_trap) begin
        bp_hit <= 1'b1;
      end else if ((state == HALT) && (state_next != HALT)) begin
        bp_hit <= 1'b0;
      end
    end
  end
`endif

  k2_prog_ram #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr),
    .wdata(ld_data),
    .raddr(ProgramAddress),
    .rdata(instruction_data)
  );

endmodule
